// File: rtl/capt_sched.sv
`default_nettype none
// ============================================================================
// Module   : capt_sched
// Purpose  : Capture scheduler for the DMA write controller. Queues packet
//            descriptors, validates them against the session snapshot,
//            launches the write controller one packet at a time and keeps
//            packet/drop counters, the capture-limit flag and a WAIT timeout.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset                 : clock, asynchronous active-high reset
//   desc_valid/desc_ready      : descriptor handshake
//   desc_begin/desc_end        : packet byte range [begin, end)
//   cfg_enable/cfg_clear       : capture enable, counter/flag clear pulse
//   cfg_control/cfg_buf_start/
//   cfg_buf_size               : session parameters, snapshot on enable rise
//   cfg_max_pkts               : capture limit (0 = unlimited)
//   wr_ctrl                    : one-cycle launch pulse
//   pkt_begin/pkt_end/
//   capt_buf_start/capt_buf_size/control : registered launch operands
//   wr_ctrl_rdy/last_write_addr: completion pulse and write pointer
//   busy, capt_done, err_timeout, pkt_count, drop_count, last_addr : status
// ============================================================================
module capt_sched #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        desc_valid,
   output logic        desc_ready,
   input  logic [31:0] desc_begin,
   input  logic [31:0] desc_end,
   input  logic        cfg_enable,
   input  logic        cfg_clear,
   input  logic [31:0] cfg_control,
   input  logic [31:0] cfg_buf_start,
   input  logic [31:0] cfg_buf_size,
   input  logic [15:0] cfg_max_pkts,
   output logic        wr_ctrl,
   output logic [31:0] pkt_begin,
   output logic [31:0] pkt_end,
   output logic [31:0] capt_buf_start,
   output logic [31:0] capt_buf_size,
   output logic [31:0] control,
   input  logic        wr_ctrl_rdy,
   input  logic [31:0] last_write_addr,
   output logic        busy,
   output logic        capt_done,
   output logic        err_timeout,
   output logic [31:0] pkt_count,
   output logic [31:0] drop_count,
   output logic [31:0] last_addr
);

   localparam int          AW         = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C    = (AW+1)'(DEPTH);
   localparam logic [15:0] TIMEOUT_C  = 16'(TIMEOUT);

   localparam logic [1:0]  ST_IDLE    = 2'd0;
   localparam logic [1:0]  ST_LAUNCH  = 2'd1;
   localparam logic [1:0]  ST_WAIT    = 2'd2;

   logic [1:0]    state;
   logic [1:0]    next_state;

   // descriptor queue
   logic [31:0]   q_begin [DEPTH];
   logic [31:0]   q_end   [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   // session snapshot
   logic          enable_q;
   logic [31:0]   snap_buf_start;
   logic [31:0]   snap_buf_size;
   logic [31:0]   snap_control;

   logic          enable_rise;
   logic [31:0]   eff_buf_start;
   logic [31:0]   eff_buf_size;
   logic [31:0]   eff_control;

   logic [32:0]   need_bytes;
   logic          reject;
   logic          handshake;
   logic          push;
   logic          drop;
   logic          pop;
   logic          complete;
   logic [31:0]   pkt_inc;
   logic [31:0]   drop_inc;
   logic [15:0]   wait_cnt;

   // On the enable rising edge the snapshot registers are being loaded this
   // very cycle, so validation and a launch in that cycle use the live values.
   assign enable_rise   = cfg_enable & ~enable_q;
   assign eff_buf_start = enable_rise ? cfg_buf_start : snap_buf_start;
   assign eff_buf_size  = enable_rise ? cfg_buf_size  : snap_buf_size;
   assign eff_control   = enable_rise ? cfg_control   : snap_control;

   // 33-bit so that a huge packet plus the 16-byte header cannot wrap
   assign need_bytes = {1'b0, desc_end - desc_begin} + 33'd16;
   assign reject     = ~cfg_enable | capt_done | (desc_end <= desc_begin) |
                       (need_bytes > {1'b0, eff_buf_size});

   assign handshake = desc_valid & desc_ready;
   assign push      = handshake & ~reject;
   assign drop      = handshake & reject;
   assign pop       = (state == ST_IDLE) && (count != '0) && cfg_enable && !capt_done;
   assign complete  = (state == ST_WAIT) && wr_ctrl_rdy;

   assign pkt_inc  = (pkt_count  == 32'hFFFF_FFFF) ? pkt_count  : pkt_count  + 32'd1;
   assign drop_inc = (drop_count == 32'hFFFF_FFFF) ? drop_count : drop_count + 32'd1;

   // ---------------------------------------------------------------- FSM ---
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:   if (pop) next_state = ST_LAUNCH;
         ST_LAUNCH: next_state = ST_WAIT;
         ST_WAIT:   if (wr_ctrl_rdy) next_state = ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      wr_ctrl    = (state == ST_LAUNCH);
      busy       = (state != ST_IDLE) || (count != '0);
      desc_ready = (count != DEPTH_C);
   end

   // -------------------------------------------------------------- queue ---
   // Storage needs no reset: pointers/count define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         q_begin[wr_ptr] <= desc_begin;
         q_end[wr_ptr]   <= desc_end;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // ----------------------------------------------------------- snapshot ---
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         enable_q       <= 1'b0;
         snap_buf_start <= '0;
         snap_buf_size  <= '0;
         snap_control   <= '0;
      end else begin
         enable_q <= cfg_enable;
         if (enable_rise) begin
            snap_buf_start <= cfg_buf_start;
            snap_buf_size  <= cfg_buf_size;
            snap_control   <= cfg_control;
         end
      end
   end

   // ----------------------------------------------------- launch operands ---
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pkt_begin      <= '0;
         pkt_end        <= '0;
         capt_buf_start <= '0;
         capt_buf_size  <= '0;
         control        <= '0;
      end else if (pop) begin
         pkt_begin      <= q_begin[rd_ptr];
         pkt_end        <= q_end[rd_ptr];
         capt_buf_start <= eff_buf_start;
         capt_buf_size  <= eff_buf_size;
         control        <= eff_control;
      end
   end

   // ---------------------------------------------------- counters / flags ---
   // cfg_clear has priority over any same-edge increment or flag set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pkt_count  <= '0;
         drop_count <= '0;
         capt_done  <= 1'b0;
         last_addr  <= '0;
      end else begin
         if (complete) last_addr <= last_write_addr;

         if (cfg_clear)     pkt_count <= '0;
         else if (complete) pkt_count <= pkt_inc;

         if (cfg_clear) drop_count <= '0;
         else if (drop) drop_count <= drop_inc;

         if (cfg_clear)
            capt_done <= 1'b0;
         else if (complete && (cfg_max_pkts != 16'd0) && (pkt_inc >= {16'd0, cfg_max_pkts}))
            capt_done <= 1'b1;
      end
   end

   // WAIT timeout: counter restarts on every entry to WAIT and saturates at
   // TIMEOUT; the flag sets on the edge where the count reaches TIMEOUT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt    <= '0;
         err_timeout <= 1'b0;
      end else begin
         if (state != ST_WAIT)
            wait_cnt <= '0;
         else if (wait_cnt != TIMEOUT_C)
            wait_cnt <= wait_cnt + 16'd1;

         if (cfg_clear)
            err_timeout <= 1'b0;
         else if ((TIMEOUT_C != 16'd0) && (state == ST_WAIT) && (wait_cnt + 16'd1 == TIMEOUT_C))
            err_timeout <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_capt_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_capt_sched
// Purpose  : Self-checking bench for capt_sched. Stimulus pushes expected
//            launch operands into a scoreboard; a negedge monitor pops and
//            compares on every wr_ctrl pulse. Status checks are directed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_capt_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        desc_valid;
   logic        desc_ready;
   logic [31:0] desc_begin;
   logic [31:0] desc_end;
   logic        cfg_enable;
   logic        cfg_clear;
   logic [31:0] cfg_control;
   logic [31:0] cfg_buf_start;
   logic [31:0] cfg_buf_size;
   logic [15:0] cfg_max_pkts;
   logic        wr_ctrl;
   logic [31:0] pkt_begin;
   logic [31:0] pkt_end;
   logic [31:0] capt_buf_start;
   logic [31:0] capt_buf_size;
   logic [31:0] control;
   logic        wr_ctrl_rdy;
   logic [31:0] last_write_addr;
   logic        busy;
   logic        capt_done;
   logic        err_timeout;
   logic [31:0] pkt_count;
   logic [31:0] drop_count;
   logic [31:0] last_addr;

   capt_sched #(.DEPTH(4), .TIMEOUT(10)) dut (
      .clk(clk), .reset(reset),
      .desc_valid(desc_valid), .desc_ready(desc_ready),
      .desc_begin(desc_begin), .desc_end(desc_end),
      .cfg_enable(cfg_enable), .cfg_clear(cfg_clear),
      .cfg_control(cfg_control), .cfg_buf_start(cfg_buf_start),
      .cfg_buf_size(cfg_buf_size), .cfg_max_pkts(cfg_max_pkts),
      .wr_ctrl(wr_ctrl), .pkt_begin(pkt_begin), .pkt_end(pkt_end),
      .capt_buf_start(capt_buf_start), .capt_buf_size(capt_buf_size),
      .control(control), .wr_ctrl_rdy(wr_ctrl_rdy),
      .last_write_addr(last_write_addr), .busy(busy),
      .capt_done(capt_done), .err_timeout(err_timeout),
      .pkt_count(pkt_count), .drop_count(drop_count), .last_addr(last_addr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] b;
      logic [31:0] e;
      logic [31:0] bs;
      logic [31:0] bz;
      logic [31:0] ctl;
   } exp_t;

   exp_t        sb[$];
   int          tests      = 0;
   int          fails      = 0;
   int          launch_cnt = 0;
   int          done_cnt   = 0;
   logic [31:0] exp_bs, exp_bz, exp_ctl;

   // ------------------------------------------------------------ monitor ---
   always @(negedge clk) begin
      exp_t x;
      if (wr_ctrl === 1'b1) begin
         launch_cnt++;
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL launch_unexpected: got launch begin=%h end=%h, required no launch",
                     pkt_begin, pkt_end);
         end else begin
            x = sb.pop_front();
            if ({pkt_begin, pkt_end, capt_buf_start, capt_buf_size, control} !== x) begin
               fails++;
               $display("FAIL launch_operands: got %h/%h/%h/%h/%h, required %h/%h/%h/%h/%h",
                        pkt_begin, pkt_end, capt_buf_start, capt_buf_size, control,
                        x.b, x.e, x.bs, x.bz, x.ctl);
            end
         end
      end
   end

   // ------------------------------------------------------------ helpers ---
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   function automatic void expect_launch(input logic [31:0] b, input logic [31:0] e);
      exp_t x;
      x.b = b; x.e = e; x.bs = exp_bs; x.bz = exp_bz; x.ctl = exp_ctl;
      sb.push_back(x);
   endfunction

   // offer one descriptor; returns #1 after the handshake edge
   task automatic send_desc(input logic [31:0] b, input logic [31:0] e);
      bit done;
      done       = 0;
      desc_begin = b;
      desc_end   = e;
      desc_valid = 1'b1;
      for (int i = 0; i < 64 && !done; i++) begin
         if (desc_ready) done = 1;
         tick();
      end
      desc_valid = 1'b0;
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL desc_handshake: got no desc_ready in 64 cycles, required handshake");
      end
   endtask

   // wait until a launched packet is sitting in WAIT
   task automatic wait_wait();
      bit done;
      done = 0;
      for (int i = 0; i < 64 && !done; i++) begin
         if (launch_cnt > done_cnt && wr_ctrl == 1'b0) done = 1;
         else tick();
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL wait_launch: got no launch in 64 cycles, required launch");
      end
   endtask

   task automatic ack(input logic [31:0] addr);
      last_write_addr = addr;
      wr_ctrl_rdy     = 1'b1;
      tick();
      wr_ctrl_rdy     = 1'b0;
      done_cnt++;
   endtask

   task automatic complete(input logic [31:0] addr);
      wait_wait();
      ack(addr);
   endtask

   task automatic clear_pulse();
      cfg_clear = 1'b1;
      tick();
      cfg_clear = 1'b0;
   endtask

   // ----------------------------------------------------------- watchdog ---
   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   // ----------------------------------------------------------- stimulus ---
   initial begin
      int lc;
      reset = 1'b1; desc_valid = 0; desc_begin = 0; desc_end = 0;
      cfg_enable = 0; cfg_clear = 0; cfg_control = 0; cfg_buf_start = 0;
      cfg_buf_size = 0; cfg_max_pkts = 0; wr_ctrl_rdy = 0; last_write_addr = 0;
      tick(); tick();

      check("rst_desc_ready", desc_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_wr_ctrl", wr_ctrl, 0);
      check("rst_pkt_count", pkt_count, 0);
      check("rst_control", control, 0);
      reset = 1'b0;
      tick();

      // single packet
      cfg_buf_start = 32'h1000; cfg_buf_size = 32'h400; cfg_control = 32'hC0DE_0001;
      cfg_enable = 1'b1;
      tick();
      exp_bs = 32'h1000; exp_bz = 32'h400; exp_ctl = 32'hC0DE_0001;
      expect_launch(32'h200, 32'h240);
      send_desc(32'h200, 32'h240);
      check("latency_at_accept", wr_ctrl, 0);
      check("busy_queued", busy, 1);
      tick();
      check("launch_pulse_e1", wr_ctrl, 1);
      check("launch_begin", pkt_begin, 32'h200);
      tick();
      check("launch_pulse_e2", wr_ctrl, 0);
      ack(32'h1050);
      check("single_pkt_count", pkt_count, 1);
      check("single_last_addr", last_addr, 32'h1050);
      check("single_idle", busy, 0);

      // rejects
      send_desc(32'h300, 32'h300);
      check("drop_empty_pkt", drop_count, 1);
      send_desc(32'h0, 32'h3F8);
      check("drop_too_long", drop_count, 2);
      expect_launch(32'h0, 32'h3F0);
      send_desc(32'h0, 32'h3F0);
      check("accept_exact_fit", drop_count, 2);
      complete(32'h1400);
      cfg_enable = 1'b0;
      tick();
      send_desc(32'h10, 32'h20);
      check("drop_disabled", drop_count, 3);
      check("pkt_count_after_rejects", pkt_count, 2);

      // queue full; config edits while enabled must be ignored
      cfg_control = 32'h0000_00AB; cfg_buf_start = 32'h2000; cfg_buf_size = 32'h100;
      cfg_enable = 1'b1;
      tick();
      exp_bs = 32'h2000; exp_bz = 32'h100; exp_ctl = 32'h0000_00AB;
      cfg_buf_start = 32'h9999_0000; cfg_control = 32'h0000_DEAD;
      for (int i = 0; i < 5; i++) begin
         expect_launch(32'(i * 16), 32'(i * 16 + 8));
         send_desc(32'(i * 16), 32'(i * 16 + 8));
      end
      check("queue_full_ready", desc_ready, 0);
      expect_launch(32'h50, 32'h58);
      desc_begin = 32'h50; desc_end = 32'h58; desc_valid = 1'b1;
      tick();
      check("full_ready_held", desc_ready, 0);
      ack(32'h2100);
      check("ready_low_on_completion", desc_ready, 0);
      tick();
      check("back_to_back_launch", wr_ctrl, 1);
      check("ready_after_pop", desc_ready, 1);
      tick();
      desc_valid = 1'b0;
      ack(32'h2101);
      for (int i = 0; i < 4; i++) complete(32'h2200 + 32'(i));
      check("pkt_count_after_full", pkt_count, 8);
      check("last_addr_after_full", last_addr, 32'h2203);

      // capture limit
      clear_pulse();
      check("clear_pkt_count", pkt_count, 0);
      check("clear_drop_count", drop_count, 0);
      cfg_max_pkts = 16'd2;
      for (int i = 0; i < 3; i++) begin
         expect_launch(32'h400 + 32'(i * 32), 32'h410 + 32'(i * 32));
         send_desc(32'h400 + 32'(i * 32), 32'h410 + 32'(i * 32));
      end
      complete(32'h3000);
      complete(32'h3004);
      check("limit_capt_done", capt_done, 1);
      check("limit_pkt_count", pkt_count, 2);
      lc = launch_cnt;
      repeat (5) tick();
      check("limit_holds_queue", 32'(launch_cnt - lc), 0);
      check("limit_busy", busy, 1);
      send_desc(32'h500, 32'h510);
      check("drop_after_done", drop_count, 1);
      clear_pulse();
      check("clear_capt_done", capt_done, 0);
      check("clear_drop_after_done", drop_count, 0);
      complete(32'h3008);
      check("resume_pkt_count", pkt_count, 1);
      check("resume_last_addr", last_addr, 32'h3008);
      cfg_max_pkts = 16'd0;

      // timeout
      clear_pulse();
      check("pre_timeout_err", err_timeout, 0);
      expect_launch(32'h600, 32'h610);
      send_desc(32'h600, 32'h610);
      wait_wait();
      repeat (9) tick();
      check("timeout_not_yet", err_timeout, 0);
      tick();
      check("timeout_set", err_timeout, 1);
      ack(32'h4000);
      check("late_rdy_pkt_count", pkt_count, 1);
      check("timeout_sticky", err_timeout, 1);

      // clear coinciding with completion
      expect_launch(32'h700, 32'h710);
      send_desc(32'h700, 32'h710);
      wait_wait();
      cfg_clear = 1'b1;
      ack(32'h5000);
      cfg_clear = 1'b0;
      check("clear_vs_complete_count", pkt_count, 0);
      check("clear_vs_complete_err", err_timeout, 0);
      check("clear_vs_complete_addr", last_addr, 32'h5000);
      check("clear_vs_complete_idle", busy, 0);

      // reset mid-WAIT with three queued
      expect_launch(32'h800, 32'h810);
      send_desc(32'h800, 32'h810);
      send_desc(32'h820, 32'h830);
      send_desc(32'h840, 32'h850);
      send_desc(32'h860, 32'h870);
      check("pre_reset_busy", busy, 1);
      #2 reset = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_desc_ready", desc_ready, 1);
      check("arst_last_addr", last_addr, 0);
      check("arst_pkt_begin", pkt_begin, 0);
      check("arst_capt_buf_start", capt_buf_start, 0);
      done_cnt = launch_cnt;
      tick();
      reset = 1'b0;
      lc = launch_cnt;
      repeat (6) tick();
      check("no_launch_after_reset", 32'(launch_cnt - lc), 0);
      check("idle_after_reset", busy, 0);
      // enable still high: a fresh snapshot is taken after reset
      exp_bs = 32'h9999_0000; exp_bz = 32'h100; exp_ctl = 32'h0000_DEAD;
      expect_launch(32'h900, 32'h910);
      send_desc(32'h900, 32'h910);
      complete(32'h6000);
      check("post_reset_pkt_count", pkt_count, 1);

      tick();
      check("scoreboard_drained", 32'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
